// File: rtl/wall_renderer.sv
// Per-pixel wall renderer: looks up the current column's trace and colours the scanline
// as ceiling, wall or floor, with syncs delayed to match the two-stage colour pipeline.
module wall_renderer #(
  parameter int         H_VIEW    = 640,
  parameter int         V_VIEW    = 480,
  parameter int         HORIZON   = 240,
  parameter int         MAX_HALF  = 240,
  parameter logic [5:0] C_CEIL    = 6'b000001,
  parameter logic [5:0] C_FLOOR   = 6'b010101,
  parameter logic [5:0] C_WALL_EW = 6'b100000,
  parameter logic [5:0] C_WALL_NS = 6'b110000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] h,
  input  logic [9:0] v,
  input  logic       visible,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic       tb_cs,
  output logic       tb_oe,
  output logic       tb_we,
  output logic [9:0] tb_column,
  input  logic [7:0] tb_height,
  input  logic       tb_side,
  output logic [5:0] rgb,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       tb_free
);

  typedef enum logic {RELEASED, ACTIVE} state_t;

  state_t     r_state;
  logic       r_free;
  logic [9:0] r_col;
  logic [9:0] r_v_p1;
  logic       r_vis_p1;
  logic       r_hs_p1;
  logic       r_vs_p1;
  logic [5:0] r_rgb_p2;
  logic       r_hs_p2;
  logic       r_vs_p2;

  logic       w_frame_start;
  logic       w_frame_end;
  logic       w_active;
  logic       w_col_ok;

  function automatic logic [5:0] pixel_colour(input logic [9:0] vv, input logic vis,
                                              input logic [7:0] ht, input logic sd);
    logic [9:0] hh;
    logic [9:0] top;
    logic [9:0] bot;
    hh  = ({2'b00, ht} > MAX_HALF[9:0]) ? MAX_HALF[9:0] : {2'b00, ht};
    top = HORIZON[9:0] - hh;
    bot = HORIZON[9:0] + hh;
    if (!vis)                         pixel_colour = 6'd0;
    else if (vv >= top && vv < bot)   pixel_colour = sd ? C_WALL_NS : C_WALL_EW;
    else if (vv < HORIZON[9:0])       pixel_colour = C_CEIL;
    else                              pixel_colour = C_FLOOR;
  endfunction

  // The frame-start sample is already rendered as owned, before the state register catches up.
  assign w_frame_start = (v == 10'd0) && (h == 10'd0);
  assign w_frame_end   = (v == V_VIEW[9:0]) && (h == 10'd0);
  assign w_active      = (r_state == ACTIVE) || w_frame_start;
  assign w_col_ok      = visible && (h < H_VIEW[9:0]);

  assign tb_cs     = w_active && (visible || r_vis_p1);
  assign tb_oe     = tb_cs;
  assign tb_we     = 1'b0;
  assign tb_column = w_col_ok ? h : r_col;
  assign tb_free   = r_free;
  assign rgb       = r_rgb_p2;
  assign hsync_out = r_hs_p2;
  assign vsync_out = r_vs_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RELEASED;
      r_free  <= 1'b1;
    end else begin
      case (r_state)
        RELEASED: if (w_frame_start) begin
          r_state <= ACTIVE;
          r_free  <= 1'b0;
        end
        ACTIVE: if (w_frame_end) begin
          r_state <= RELEASED;
          r_free  <= 1'b1;
        end
        default: begin
          r_state <= RELEASED;
          r_free  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_col <= 10'd0;
    else if (w_col_ok) r_col <= h;
  end

  // Stage 1: align position and syncs with the trace buffer's registered read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v_p1   <= 10'd0;
      r_vis_p1 <= 1'b0;
      r_hs_p1  <= 1'b0;
      r_vs_p1  <= 1'b0;
    end else begin
      r_v_p1   <= v;
      r_vis_p1 <= visible && w_active;
      r_hs_p1  <= hsync_in;
      r_vs_p1  <= vsync_in;
    end
  end

  // Stage 2: colour decision and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb_p2 <= 6'd0;
      r_hs_p2  <= 1'b1;
      r_vs_p2  <= 1'b1;
    end else begin
      r_rgb_p2 <= pixel_colour(r_v_p1, r_vis_p1, tb_height, tb_side);
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
    end
  end

endmodule
